// File: rtl/positron_layer_sequencer.sv
// ----------------------------------------------------------------------------
// positron_layer_sequencer
//
// Frame controller for one positron layer. It sits between the upstream posit
// stream and the layer datapath (positron array plus memory-to-stream drain).
// It cuts the input stream into frames of NB_UPSTREAM_POSITRON words and marks
// the first and last word of each frame. It also stalls upstream until the
// previous frame's NB_POSITRON results have drained. A DMA tlast seen on input
// is carried to the last drained result word.
//
// Optional feature (compile-time macro POSITRON_SEQ_PAD_SHORT_FRAME_EN):
//   defined   - an early eow_i ends input and the frame is completed with
//               posit-zero pad words (PAD state).
//   undefined - an early eow_i closes the frame on that word and flags err_o.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   rts_i/rtr_o   upstream valid/ready; eow_i = upstream tlast
//   dp_rts_o      datapath word valid; dp_rtr_i = datapath ready
//   dp_sow_o      first word of frame (qualified by dp_rts_o)
//   dp_eow_o      last word of frame (qualified by dp_rts_o)
//   dp_pad_o      datapath substitutes posit zero for the input word
//   acc_done_i    one-cycle pulse: datapath finished accumulating the frame
//   drn_rts_i     drain output valid (monitored only)
//   drn_rtr_i     downstream ready (monitored only)
//   eow_o         downstream tlast on the last drained word
//   busy_o        a frame is in flight
//   err_o         sticky protocol error
//   frame_cnt_o   frames fully drained (wraps)
// ----------------------------------------------------------------------------
module positron_layer_sequencer #(
    parameter int NB_UPSTREAM_POSITRON = 784,
    parameter int NB_POSITRON          = 20,
    parameter int FRAME_CNT_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rts_i,
    output logic                       rtr_o,
    input  logic                       eow_i,
    output logic                       dp_rts_o,
    input  logic                       dp_rtr_i,
    output logic                       dp_sow_o,
    output logic                       dp_eow_o,
    output logic                       dp_pad_o,
    input  logic                       acc_done_i,
    input  logic                       drn_rts_i,
    input  logic                       drn_rtr_i,
    output logic                       eow_o,
    output logic                       busy_o,
    output logic                       err_o,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o
);

    localparam int WC_W = $clog2(NB_UPSTREAM_POSITRON);
    localparam int DC_W = $clog2(NB_POSITRON) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(NB_UPSTREAM_POSITRON - 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(NB_POSITRON - 1);

    typedef enum logic [1:0] {
        ACCUM    = 2'd0,
        WAIT_ACC = 2'd1,
        DRAIN    = 2'd2
`ifdef POSITRON_SEQ_PAD_SHORT_FRAME_EN
        ,PAD     = 2'd3
`endif
    } state_t;

    state_t                     state, state_nxt;
    logic [WC_W-1:0]            wc, wc_nxt;
    logic [DC_W-1:0]            dc, dc_nxt;
    logic                       tlast_lat, tlast_nxt;
    logic                       err_nxt;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_nxt;

    logic hs;
    logic drn_hs;
    logic wc_last;

    assign busy_o = (state != ACCUM) || (wc != '0);

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_nxt     = state;
        wc_nxt        = wc;
        dc_nxt        = dc;
        tlast_nxt     = tlast_lat;
        err_nxt       = err_o;
        frame_cnt_nxt = frame_cnt_o;
        rtr_o         = 1'b0;
        dp_rts_o      = 1'b0;
        dp_sow_o      = 1'b0;
        dp_eow_o      = 1'b0;
        dp_pad_o      = 1'b0;
        eow_o         = 1'b0;
        hs            = 1'b0;
        drn_hs        = drn_rts_i & drn_rtr_i;
        wc_last       = (wc == WC_LAST);

        case (state)
            ACCUM: begin
                // Zero-latency pass-through: upstream sees the datapath ready.
                rtr_o    = dp_rtr_i;
                dp_rts_o = rts_i;
                hs       = rts_i & dp_rtr_i;
                dp_sow_o = rts_i & (wc == '0);
`ifdef POSITRON_SEQ_PAD_SHORT_FRAME_EN
                dp_eow_o = rts_i & wc_last;
`else
                // A short frame is closed on the word carrying eow_i.
                dp_eow_o = rts_i & (wc_last | eow_i);
`endif
                if (acc_done_i) err_nxt = 1'b1;
                if (hs) begin
                    if (eow_i) tlast_nxt = 1'b1;
                    if (wc_last) begin
                        wc_nxt    = '0;
                        state_nxt = WAIT_ACC;
                    end else if (eow_i) begin
`ifdef POSITRON_SEQ_PAD_SHORT_FRAME_EN
                        wc_nxt    = wc + 1'b1;
                        state_nxt = PAD;
`else
                        wc_nxt    = '0;
                        state_nxt = WAIT_ACC;
                        err_nxt   = 1'b1;
`endif
                    end else begin
                        wc_nxt = wc + 1'b1;
                    end
                end
            end

`ifdef POSITRON_SEQ_PAD_SHORT_FRAME_EN
            PAD: begin
                // Upstream is held off while zeros fill the rest of the frame.
                dp_rts_o = 1'b1;
                dp_pad_o = 1'b1;
                dp_eow_o = wc_last;
                if (dp_rtr_i) begin
                    if (wc_last) begin
                        wc_nxt    = '0;
                        state_nxt = WAIT_ACC;
                    end else begin
                        wc_nxt = wc + 1'b1;
                    end
                end
            end
`endif

            WAIT_ACC: begin
                if (acc_done_i) begin
                    dc_nxt    = '0;
                    state_nxt = DRAIN;
                end
            end

            DRAIN: begin
                if (acc_done_i) err_nxt = 1'b1;
                if (drn_hs) begin
                    if (dc == DC_LAST) begin
                        eow_o         = tlast_lat;
                        tlast_nxt     = 1'b0;
                        frame_cnt_nxt = frame_cnt_o + 1'b1;
                        dc_nxt        = '0;
                        state_nxt     = ACCUM;
                    end else begin
                        dc_nxt = dc + 1'b1;
                    end
                end
            end

            default: state_nxt = ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            wc          <= '0;
            dc          <= '0;
            tlast_lat   <= 1'b0;
            err_o       <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            wc          <= wc_nxt;
            dc          <= dc_nxt;
            tlast_lat   <= tlast_nxt;
            err_o       <= err_nxt;
            frame_cnt_o <= frame_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_positron_layer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_positron_layer_sequencer
//
// Directed bench for positron_layer_sequencer with 4 words per frame and 3
// drained results per frame. Inputs change on the falling edge; outputs are
// compared 1 ns later, well away from the rising edge. Expected values are
// hand-computed constants. The short-frame expectations follow the
// POSITRON_SEQ_PAD_SHORT_FRAME_EN macro.
// ----------------------------------------------------------------------------
module tb_positron_layer_sequencer;

    localparam int N   = 4;
    localparam int NBP = 3;
    localparam int FCW = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           rts_i;
    logic           rtr_o;
    logic           eow_i;
    logic           dp_rts_o;
    logic           dp_rtr_i;
    logic           dp_sow_o;
    logic           dp_eow_o;
    logic           dp_pad_o;
    logic           acc_done_i;
    logic           drn_rts_i;
    logic           drn_rtr_i;
    logic           eow_o;
    logic           busy_o;
    logic           err_o;
    logic [FCW-1:0] frame_cnt_o;

    int errors = 0;
    int checks = 0;

    positron_layer_sequencer #(
        .NB_UPSTREAM_POSITRON(N),
        .NB_POSITRON         (NBP),
        .FRAME_CNT_WIDTH     (FCW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rts_i      (rts_i),
        .rtr_o      (rtr_o),
        .eow_i      (eow_i),
        .dp_rts_o   (dp_rts_o),
        .dp_rtr_i   (dp_rtr_i),
        .dp_sow_o   (dp_sow_o),
        .dp_eow_o   (dp_eow_o),
        .dp_pad_o   (dp_pad_o),
        .acc_done_i (acc_done_i),
        .drn_rts_i  (drn_rts_i),
        .drn_rtr_i  (drn_rtr_i),
        .eow_o      (eow_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Four upstream words; eow_i on word eow_at (use N or more for none).
    // The frame must end normally on word N-1.
    task automatic feed_frame(input int eow_at);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            rts_i    = 1'b1;
            dp_rtr_i = 1'b1;
            eow_i    = (k == eow_at);
            #1;
            check($sformatf("w%0d_dp_rts", k), 32'(dp_rts_o), 32'd1);
            check($sformatf("w%0d_rtr", k),    32'(rtr_o),    32'd1);
            check($sformatf("w%0d_sow", k),    32'(dp_sow_o), 32'(k == 0));
            check($sformatf("w%0d_eow", k),    32'(dp_eow_o), 32'(k == N - 1));
        end
        // Keep offering a word while the sequencer waits for the datapath.
        @(negedge clk);
        eow_i = 1'b0;
        rts_i = 1'b1;
        #1;
        check("wait_rtr",    32'(rtr_o),    32'd0);
        check("wait_dp_rts", 32'(dp_rts_o), 32'd0);
        check("wait_busy",   32'(busy_o),   32'd1);
    endtask

    task automatic pulse_acc_done();
        @(negedge clk);
        acc_done_i = 1'b1;
        #1;
        check("acc_rtr", 32'(rtr_o), 32'd0);
        @(negedge clk);
        acc_done_i = 1'b0;
        #1;
        check("drain_entry_rtr", 32'(rtr_o), 32'd0);
    endtask

    // Three drain handshakes, optionally with downstream ready toggling.
    task automatic drain(input bit exp_tlast, input bit toggle, input int exp_cnt);
        int hsn = 0;
        for (int c = 0; c < 10 && hsn < NBP; c++) begin
            @(negedge clk);
            drn_rts_i = 1'b1;
            drn_rtr_i = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            if (drn_rtr_i) hsn++;
            check($sformatf("drn%0d_eow", c),    32'(eow_o),    32'((hsn == NBP) && drn_rtr_i && exp_tlast));
            check($sformatf("drn%0d_rtr", c),    32'(rtr_o),    32'd0);
            check($sformatf("drn%0d_dp_rts", c), 32'(dp_rts_o), 32'd0);
        end
        check("drain_handshakes", 32'(hsn), 32'(NBP));
        @(negedge clk);
        drn_rts_i = 1'b0;
        drn_rtr_i = 1'b0;
        rts_i     = 1'b0;
        #1;
        check("frame_cnt", 32'(frame_cnt_o), 32'(exp_cnt));
        check("post_rtr",  32'(rtr_o),       32'd1);
        check("post_busy", 32'(busy_o),      32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        rts_i      = 1'b0;
        eow_i      = 1'b0;
        dp_rtr_i   = 1'b0;
        acc_done_i = 1'b0;
        drn_rts_i  = 1'b0;
        drn_rtr_i  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rtr",       32'(rtr_o),       32'd0);
        check("rst_dp_rts",    32'(dp_rts_o),    32'd0);
        check("rst_sow",       32'(dp_sow_o),    32'd0);
        check("rst_eow_o",     32'(eow_o),       32'd0);
        check("rst_busy",      32'(busy_o),      32'd0);
        check("rst_err",       32'(err_o),       32'd0);
        check("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1: plain frame, drain with downstream ready toggling.
        feed_frame(N);
        pulse_acc_done();
        drain(1'b0, 1'b1, 1);

        // Frame 2: tlast on the last word reaches the last drained word.
        feed_frame(N - 1);
        pulse_acc_done();
        drain(1'b1, 1'b0, 2);
        check("f2_err", 32'(err_o), 32'd0);

        // Frame 3: no tlast, so eow_o stays low.
        feed_frame(N);
        pulse_acc_done();
        drain(1'b0, 1'b0, 3);

        // Frame 4: short frame, eow_i on word 1.
        @(negedge clk);
        rts_i    = 1'b1;
        dp_rtr_i = 1'b1;
        eow_i    = 1'b0;
        #1;
        check("s_w0_sow", 32'(dp_sow_o), 32'd1);
        @(negedge clk);
        eow_i = 1'b1;
        #1;
`ifdef POSITRON_SEQ_PAD_SHORT_FRAME_EN
        check("s_w1_eow", 32'(dp_eow_o), 32'd0);
        @(negedge clk);
        rts_i = 1'b0;
        eow_i = 1'b0;
        #1;
        check("pad2_pad",    32'(dp_pad_o), 32'd1);
        check("pad2_dp_rts", 32'(dp_rts_o), 32'd1);
        check("pad2_rtr",    32'(rtr_o),    32'd0);
        check("pad2_eow",    32'(dp_eow_o), 32'd0);
        @(negedge clk);
        #1;
        check("pad3_pad", 32'(dp_pad_o), 32'd1);
        check("pad3_eow", 32'(dp_eow_o), 32'd1);
        @(negedge clk);
        #1;
        check("pad_done_dp_rts", 32'(dp_rts_o), 32'd0);
        check("pad_done_pad",    32'(dp_pad_o), 32'd0);
        check("pad_err",         32'(err_o),    32'd0);
`else
        check("s_w1_eow", 32'(dp_eow_o), 32'd1);
        @(negedge clk);
        rts_i = 1'b0;
        eow_i = 1'b0;
        #1;
        check("short_err",  32'(err_o),    32'd1);
        check("short_pad",  32'(dp_pad_o), 32'd0);
        check("short_rtr",  32'(rtr_o),    32'd0);
        check("short_busy", 32'(busy_o),   32'd1);
`endif
        pulse_acc_done();
        drain(1'b1, 1'b0, 4);

        // Frame 5: tlast latched, then reset arrives mid-drain (dc=1).
        feed_frame(N - 1);
        pulse_acc_done();
        @(negedge clk);
        drn_rts_i = 1'b1;
        drn_rtr_i = 1'b1;
        #1;
        check("f5_drn0_eow", 32'(eow_o), 32'd0);
        @(negedge clk);
        drn_rtr_i = 1'b0;
        rts_i     = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        check("mid_rst_err",       32'(err_o),       32'd0);
        check("mid_rst_busy",      32'(busy_o),      32'd0);
        check("mid_rst_rtr",       32'(rtr_o),       32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        drn_rts_i = 1'b0;

        // Frame 6: the cleared tlast latch must not leak into this frame.
        feed_frame(N);
        pulse_acc_done();
        drain(1'b0, 1'b0, 1);

        // A stray acc_done_i in ACCUM is a protocol error and is otherwise ignored.
        @(negedge clk);
        acc_done_i = 1'b1;
        #1;
        @(negedge clk);
        acc_done_i = 1'b0;
        #1;
        check("stray_acc_err",  32'(err_o),  32'd1);
        check("stray_acc_rtr",  32'(rtr_o),  32'd1);
        check("stray_acc_busy", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
